cdb_arbiter: RTL
================

// Module: cdb_arbiter
// PURPOSE
// - Shares the single common data bus (CDB) among result producers: ALU, load/store buffer, and the
//   issue-side direct path (LUI/AUIPC/JAL rd values from the IQueue/WB mux).
// - Each producer gets a 1-entry holding slot; a round-robin arbiter broadcasts one slot per cycle
//   as a registered CDB beat (tag + value) to ROB, RS and LSB.
// PARAMETERS
// - NUM_SRC  3   number of producers; index 0 = ALU, 1 = LSB, 2 = direct/imm path
// - TAG_W    4   ROB tag width
// - DATA_W   32  result value width
// PORTS
// - clk        in   1                 clock
// - rst        in   1                 reset, synchronous, active-high
// - rdy        in   1                 global ready; low = freeze all state, outputs hold
// - flush      in   1                 branch mispredict clear from ROB
// - src_valid  in   NUM_SRC           producer i presents a result
// - src_tag    in   NUM_SRC*TAG_W     ROB tag, slice i = [i*TAG_W +: TAG_W]
// - src_value  in   NUM_SRC*DATA_W    result, slice i = [i*DATA_W +: DATA_W]
// - src_ready  out  NUM_SRC           slot i can accept this cycle (combinational)
// - cdb_valid  out  1                 registered broadcast valid
// - cdb_src    out  $clog2(NUM_SRC)   index of source broadcast
// - cdb_tag    out  TAG_W             broadcast ROB tag
// - cdb_value  out  DATA_W            broadcast value
// BEHAVIOUR
// - Reset: held[] = 0, ptr = 0, cdb_valid = 0, cdb_src/cdb_tag/cdb_value = 0. rst overrides rdy.
// - rdy low: no accept, no grant, no flush action; all registers hold; src_ready forced 0.
// - grant: one-hot, combinational; first i with held[i] scanning ptr, ptr+1, ... mod NUM_SRC.
//   Depends only on held[] and ptr, never on src_valid (no combinational loop).
// - src_ready[i] = rdy && !flush && (!held[i] || grant[i]) -> one result per source per cycle.
// - Accept: src_valid[i] && src_ready[i] at edge -> slot i loads tag/value, held[i] = 1.
// - Grant at edge: cdb_valid <= 1, cdb_src/tag/value <= granted slot; held[i] cleared unless
//   refilled by a same-cycle accept; ptr <= (i+1) mod NUM_SRC.
// - No held slot: cdb_valid <= 0 (tag/value may hold stale data); ptr unchanged.
// - Latency: accept at edge t -> earliest cdb_valid high after edge t+1 (no bypass input->CDB).
// - src_valid without src_ready: producer must hold value/tag stable until accepted.
// - Flush (rdy high): held[] <= 0, cdb_valid <= 0, same-cycle accepts dropped, ptr unchanged.
// - Fairness: with all slots continuously full, each source broadcasts exactly once per NUM_SRC cycles.
// - ptr wraps NUM_SRC-1 -> 0; NUM_SRC not a power of two must be handled (no bit truncation wrap).
// STRUCTURE
// - const.v additions: `CDB_SRC_ALU 0, `CDB_SRC_LSB 1, `CDB_SRC_IMM 2, `ROB_TAG_W 4.
// - Sub-module rr_pick: combinational round-robin picker (req vector, ptr -> one-hot grant, index,
//   any). Holding slots, ptr and CDB output registers stay in cdb_arbiter.
// TESTING
// - Reset: rst high 2 cycles with all src_valid=1 -> cdb_valid=0, src_ready=0 (rst) then all 1.
// - Single: ALU valid tag=3 value=0x1234 one cycle -> cdb_valid 2nd edge, src=0, tag=3, value=0x1234.
// - Contention: all 3 valid tags 1,2,3 same cycle -> broadcasts order src 0,1,2 on 3 consecutive cycles.
// - Streaming: LSB valid every cycle, tags 0..7, others idle -> 8 back-to-back beats, src_ready[1]
//   stays 1, no bubble after first.
// - Fairness: all sources valid continuously 30 cycles -> each source exactly 10 beats, rotation
//   0,1,2 repeating.
// - Flush/freeze: 2 slots held, flush=1 with new ALU valid -> next cycle cdb_valid=0, no held slot,
//   ALU result lost; rdy=0 for 3 cycles mid-stream -> CDB outputs and order unchanged on resume.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and helpers for the common data bus arbiter.
// Source indices identify which producer a CDB beat came from.
package cdb_arbiter_pkg;

    localparam int CDB_SRC_ALU = 0;
    localparam int CDB_SRC_LSB = 1;
    localparam int CDB_SRC_IMM = 2;
    localparam int ROB_TAG_W   = 4;
    localparam int CDB_NUM_SRC = 3;
    localparam int CDB_DATA_W  = 32;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_LSB = 2'd1,
        SRC_IMM = 2'd2
    } cdb_src_e;

    // Index width that stays at least one bit wide for a single producer.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Round-robin successor; explicit compare so non-power-of-two counts wrap correctly.
    function automatic int rr_next(input int cur, input int n);
        if (cur + 1 >= n) return 0;
        return cur + 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side handshake and CDB broadcast bundle.
// master = producers/consumers around the arbiter, slave = the arbiter itself.
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC = CDB_NUM_SRC,
    parameter int TAG_W   = ROB_TAG_W,
    parameter int DATA_W  = CDB_DATA_W
) ();

    localparam int SRC_W = idx_w(NUM_SRC);

    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC*TAG_W-1:0]  src_tag;
    logic [NUM_SRC*DATA_W-1:0] src_value;
    logic [NUM_SRC-1:0]        src_ready;
    logic                      cdb_valid;
    logic [SRC_W-1:0]          cdb_src;
    logic [TAG_W-1:0]          cdb_tag;
    logic [DATA_W-1:0]         cdb_value;

    modport master (
        output src_valid, src_tag, src_value,
        input  src_ready, cdb_valid, cdb_src, cdb_tag, cdb_value
    );

    modport slave (
        input  src_valid, src_tag, src_value,
        output src_ready, cdb_valid, cdb_src, cdb_tag, cdb_value
    );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Produces a one-hot grant, the granted index and an any-request flag.
module cdb_arbiter_rr_pick
    import cdb_arbiter_pkg::*;
#(
    parameter int N     = CDB_NUM_SRC,
    parameter int SRC_W = idx_w(CDB_NUM_SRC)
) (
    input  logic [N-1:0]     req,
    input  logic [SRC_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [SRC_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        // Walk offsets from farthest to nearest so the nearest hit wins.
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = SRC_W'(j);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per producer, round-robin broadcast
// of one slot per cycle as a registered CDB beat.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC = CDB_NUM_SRC,
    parameter int TAG_W   = ROB_TAG_W,
    parameter int DATA_W  = CDB_DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    input  logic          flush,
    cdb_arbiter_if.slave  bus
);

    localparam int SRC_W = idx_w(NUM_SRC);

    logic [NUM_SRC-1:0] held;
    logic [TAG_W-1:0]   slot_tag   [NUM_SRC];
    logic [DATA_W-1:0]  slot_value [NUM_SRC];
    logic [SRC_W-1:0]   ptr;

    logic [NUM_SRC-1:0] grant;
    logic [NUM_SRC-1:0] accept;
    logic [NUM_SRC-1:0] ready;
    logic [SRC_W-1:0]   pick_idx;
    logic               pick_any;
    logic [TAG_W-1:0]   pick_tag;
    logic [DATA_W-1:0]  pick_value;

    logic               cdb_valid_q;
    logic [SRC_W-1:0]   cdb_src_q;
    logic [TAG_W-1:0]   cdb_tag_q;
    logic [DATA_W-1:0]  cdb_value_q;

    // Grant looks only at held slots, so src_valid never feeds back into src_ready.
    cdb_arbiter_rr_pick #(
        .N     (NUM_SRC),
        .SRC_W (SRC_W)
    ) u_rr_pick (
        .req   (held),
        .ptr   (ptr),
        .grant (grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        pick_tag   = '0;
        pick_value = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                pick_tag   = pick_tag   | slot_tag[i];
                pick_value = pick_value | slot_value[i];
            end
        end
    end

    // A slot being broadcast this cycle can be refilled in the same cycle.
    assign ready         = (!rst && rdy && !flush) ? (~held | grant) : '0;
    assign accept        = bus.src_valid & ready;
    assign bus.src_ready = ready;

    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_src   = cdb_src_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_value = cdb_value_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            held        <= '0;
            ptr         <= '0;
            cdb_valid_q <= 1'b0;
            cdb_src_q   <= '0;
            cdb_tag_q   <= '0;
            cdb_value_q <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                slot_tag[i]   <= '0;
                slot_value[i] <= '0;
            end
        end else if (rdy) begin
            if (flush) begin
                held        <= '0;
                cdb_valid_q <= 1'b0;
            end else begin
                cdb_valid_q <= pick_any;
                if (pick_any) begin
                    cdb_src_q   <= pick_idx;
                    cdb_tag_q   <= pick_tag;
                    cdb_value_q <= pick_value;
                    ptr         <= SRC_W'(rr_next(int'(pick_idx), NUM_SRC));
                end
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (accept[i]) begin
                        held[i]       <= 1'b1;
                        slot_tag[i]   <= bus.src_tag[i*TAG_W +: TAG_W];
                        slot_value[i] <= bus.src_value[i*DATA_W +: DATA_W];
                    end else if (grant[i]) begin
                        held[i] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
